fmul_share_ctrl: RTL and testbench
==================================

Name: fmul_share_ctrl

Overview:
Sequences a single shared single-precision floating-point multiplier (the team's combinational `mul` block) between NUM_REQ requesters. Round-robin arbitration selects one requester at a time. The block registers that requester's operands onto the multiplier inputs and captures the product. It returns the product with the requester ID over a valid/ready response channel. It sits between the accelerator's compute lanes and the one multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_in1  input  32*NUM_REQ  operand A, requester i at bits [32i+31:32i].
- req_in2  input  32*NUM_REQ  operand B, same packing.
- mul_in1  output  32  registered operand A to the shared multiplier.
- mul_in2  output  32  registered operand B to the shared multiplier.
- mul_result  input  32  combinational product from the shared multiplier.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  ID_W  ID of the requester owning rsp_data.
- rsp_data  output  32  registered product.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, mul_in1=mul_in2=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, last_grant=NUM_REQ-1 (requester 0 has highest priority after reset).
- States:
  - IDLE: no operation in flight.
  - CALC: operands held on mul_in1/mul_in2 while the multiplier settles.
  - RESP: rsp_valid=1, holding the response.
- Arbitration window:
  - Open when state==IDLE, or state==RESP with rsp_ready=1.
  - Closed otherwise; req_ready=0 and no state change from requests.
- Grant rule: search from (last_grant+1) mod NUM_REQ upward with wrap, and grant the first i with req_valid[i]=1.
  - Assert req_ready[i] combinationally in that cycle; the handshake is req_valid[i]&req_ready[i].
  - On the clock edge: mul_in1<=req_in1[i], mul_in2<=req_in2[i], granted ID latched, last_grant<=i, state<=CALC.
- CALC: exactly one cycle. rsp_data<=mul_result, rsp_id<=latched ID, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_data/rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1 with no grant: rsp_valid<=0, state<=IDLE.
  - On rsp_ready=1 with a grant in the same cycle: rsp_valid<=0, state<=CALC (back-to-back, no IDLE bubble).
- Latency: handshake in cycle N -> rsp_valid high from cycle N+2. Peak throughput is one product per 2 cycles.
- mul_in1/mul_in2 hold their last values outside CALC. They change only on a grant edge.
- No requests in the window: state is unchanged (IDLE stays IDLE, RESP with rsp_ready goes to IDLE).
- A requester dropping req_valid before grant is legal; it is simply not granted.
- The product is passed through unmodified; the block does no FP interpretation (sign, exponent, zero and denormal handling belong to the multiplier).
- Reset asserted mid-operation (CALC or RESP): all state returns to reset values immediately, and the in-flight result is discarded with no response.
- At most one bit of req_ready is set in any cycle.

Test Plan:
- Single request:
  - Stimulus: after reset, req_valid=0001, in1=0x40000000, in2=0x40400000 (2.0*3.0).
  - Required: req_ready=0001 in cycle 0; rsp_valid in cycle 2 with rsp_data=0x40C00000, rsp_id=0.
- Round-robin fairness:
  - Stimulus: all four req_valid held high, rsp_ready=1.
  - Required: grant order is 0,1,2,3,0; one response every 2 cycles; no IDLE cycles between operations.
- Backpressure:
  - Stimulus: req1 with 0x3FC00000*0x3FC00000 (1.5*1.5), rsp_ready=0 for 5 cycles; req2 valid throughout.
  - Required: rsp_data=0x40100000 and rsp_id=1 held stable for all 5 cycles; req_ready=0 until the cycle rsp_ready rises; req2 is granted in that same cycle.
- Sign and zero:
  - Stimulus: 0xC0000000*0x40400000 (-2.0*3.0), then 0x00000000*0x40400000 (0.0*3.0).
  - Required: rsp_data=0xC0C00000, then rsp_data equal to the multiplier's product for zero, passed through unchanged.
- Reset mid-operation:
  - Stimulus: assert rst during CALC.
  - Required: rsp_valid=0, busy=0, and mul_in1/mul_in2 become 0 without waiting for a clock edge; the next grant after reset goes to requester 0 with others pending.
- Wrap-around:
  - Stimulus: last_grant=3, req_valid=1001.
  - Required: requester 0 is granted next, then requester 3.

Source files
------------

// File: rtl/fmul_share_ctrl.sv
// Time-shares one combinational FP multiplier between NUM_REQ requesters.
// Round-robin grant -> operand register -> product capture -> valid/ready response.
module fmul_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_in1,
  input  logic [32*NUM_REQ-1:0]   req_in2,
  output logic [31:0]             mul_in1,
  output logic [31:0]             mul_in2,
  input  logic [31:0]             mul_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } rsp_t;

  logic [NUM_REQ-1:0][31:0] op_a, op_b;
  assign op_a = req_in1;
  assign op_b = req_in2;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic [31:0]     mul_in1_q, mul_in1_d;
  logic [31:0]     mul_in2_q, mul_in2_d;
  rsp_t            rsp_q, rsp_d;
  logic            rsp_valid_q, rsp_valid_d;

  // Rotate requests so bit 0 is the requester just after last_grant.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W:0]        gnt_sum;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_found;
  logic                 window, take;

  always_comb begin
    req_dbl   = {req_valid, req_valid} >> ({1'b0, last_grant_q} + (ID_W+1)'(1));
    req_rot   = req_dbl[NUM_REQ-1:0];
    gnt_found = 1'b0;
    gnt_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_rot[k]) begin
        gnt_found = 1'b1;
        gnt_sum   = {1'b0, last_grant_q} + (ID_W+1)'(k + 1);
      end
    end
    if (gnt_sum >= (ID_W+1)'(NUM_REQ)) gnt_sum = gnt_sum - (ID_W+1)'(NUM_REQ);
    gnt_idx = gnt_sum[ID_W-1:0];
  end

  assign window = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign take   = window && gnt_found && !rst;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = take && (gnt_idx == ID_W'(i));
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    mul_in1_d    = mul_in1_q;
    mul_in2_d    = mul_in2_q;
    rsp_d        = rsp_q;
    rsp_valid_d  = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          mul_in1_d    = op_a[gnt_idx];
          mul_in2_d    = op_b[gnt_idx];
          gnt_id_d     = gnt_idx;
          last_grant_d = gnt_idx;
          state_d      = CALC;
        end
      end
      CALC: begin
        rsp_d       = '{id: gnt_id_q, data: mul_result};
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          // Grant in the same cycle the response drains: no IDLE bubble.
          if (take) begin
            mul_in1_d    = op_a[gnt_idx];
            mul_in2_d    = op_b[gnt_idx];
            gnt_id_d     = gnt_idx;
            last_grant_d = gnt_idx;
            state_d      = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      gnt_id_q     <= '0;
      mul_in1_q    <= '0;
      mul_in2_q    <= '0;
      rsp_q        <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      mul_in1_q    <= mul_in1_d;
      mul_in2_q    <= mul_in2_d;
      rsp_q        <= rsp_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign mul_in1   = mul_in1_q;
  assign mul_in2   = mul_in2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_data  = rsp_q.data;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// Bench for fmul_share_ctrl: table-driven multiplier stand-in plus a response scoreboard.
module tb_fmul_share_ctrl;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk, rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [32*NR-1:0]  req_in1, req_in2;
  logic [31:0]       mul_in1, mul_in2, mul_result;
  logic              rsp_valid, rsp_ready, busy;
  logic [IW-1:0]     rsp_id;
  logic [31:0]       rsp_data;

  int errors = 0;
  int checks = 0;
  logic [IW+31:0] sb[$];
  int grant_log[$];

  fmul_share_ctrl #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  // Stand-in for the shared multiplier: exact products for the plan's
  // operands, an arbitrary but deterministic mix for everything else.
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
      {32'hC0000000, 32'h40400000}: return 32'hC0C00000;
      {32'h00000000, 32'h40400000}: return 32'h00000000;
      {32'h3F800000, 32'h41200000}: return 32'h41200000;
      default:                      return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endcase
  endfunction

  assign mul_result = fmul_model(mul_in1, mul_in2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_in1[32*i +: 32] = a;
    req_in2[32*i +: 32] = b;
  endtask

  // One clock: record grants into the scoreboard, retire responses from it.
  task automatic cycle();
    logic [NR-1:0]  hs;
    logic [IW+31:0] exp;
    #1;
    checks++;
    if ($countones(req_ready) > 1) begin
      errors++;
      $display("FAIL req_ready_onehot: got %b required at most one bit", req_ready);
    end
    hs = req_valid & req_ready;
    for (int i = 0; i < NR; i++)
      if (hs[i]) begin
        sb.push_back({IW'(i), fmul_model(req_in1[32*i +: 32], req_in2[32*i +: 32])});
        grant_log.push_back(i);
      end
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got id=%0d data=%h required no response", rsp_id, rsp_data);
      end else begin
        exp = sb.pop_front();
        if ({rsp_id, rsp_data} !== exp) begin
          errors++;
          $display("FAIL sb_rsp: got id=%0d data=%h required id=%0d data=%h",
                   rsp_id, rsp_data, exp[IW+31:32], exp[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_in1 = '0; req_in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (mul_in1 !== 32'h0 || mul_in2 !== 32'h0) begin errors++; $display("FAIL rst_mul_in: got %h/%h required 0/0", mul_in1, mul_in2); end
    checks++; if (rsp_id !== '0 || rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp: got id=%0d data=%h required 0/0", rsp_id, rsp_data); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_req_ready: got %b required 0000", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_op(0, 32'h40000000, 32'h40400000);
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b required 0001", req_ready); end
    cycle();
    req_valid = '0;
    checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc: got busy=%b rsp_valid=%b required 1/0", busy, rsp_valid); end
    checks++; if (mul_in1 !== 32'h40000000 || mul_in2 !== 32'h40400000) begin errors++; $display("FAIL single_mul_in: got %h/%h required 40000000/40400000", mul_in1, mul_in2); end
    cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h40C00000 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL single_rsp: got v=%b data=%h id=%0d required 1/40c00000/0", rsp_valid, rsp_data, rsp_id); end
    rsp_ready = 1'b1;
    cycle();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got v=%b busy=%b required 0/0", rsp_valid, busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    rst = 1'b1; #1; rst = 1'b0;
    for (int i = 0; i < NR; i++) set_op(i, $urandom, $urandom);
    grant_log.delete();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (busy !== (c != 0) || rsp_valid !== (c >= 2 && c % 2 == 0)) begin
        errors++; $display("FAIL rr_cycle%0d: got busy=%b rsp_valid=%b required %b/%b", c, busy, rsp_valid, c != 0, c >= 2 && c % 2 == 0);
      end
      cycle();
    end
    checks++;
    if (grant_log.size() != 5 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 2 ||
        grant_log[3] != 3 || grant_log[4] != 0) begin
      errors++; $display("FAIL rr_order: got %p required 0,1,2,3,0", grant_log);
    end
    req_valid = '0;
    repeat (2) cycle();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    set_op(1, 32'h3FC00000, 32'h3FC00000);
    set_op(2, 32'h3F800000, 32'h41200000);
    req_valid = 4'b0110; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first: got %b required 0010", req_ready); end
    cycle();
    req_valid = 4'b0100;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_calc_ready: got %b required 0000", req_ready); end
    cycle();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h40100000 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b data=%h id=%0d ready=%b required 1/40100000/1/0000",
                           c, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      cycle();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release: got %b required 0100", req_ready); end
    cycle();
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_b2b: got v=%b busy=%b required 0/1", rsp_valid, busy); end
    cycle();
    checks++; if (rsp_id !== 2'd2 || rsp_data !== 32'h41200000) begin errors++; $display("FAIL bp_req2: got id=%0d data=%h required 2/41200000", rsp_id, rsp_data); end
    cycle();
    rsp_ready = 1'b0;
  endtask

  task automatic test_sign_zero();
    set_op(3, 32'hC0000000, 32'h40400000);
    req_valid = 4'b1000; rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    set_op(3, 32'h00000000, 32'h40400000);
    cycle();
    checks++; if (rsp_data !== 32'hC0C00000) begin errors++; $display("FAIL sign_neg: got %h required c0c00000", rsp_data); end
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    cycle();
    checks++; if (rsp_data !== 32'h00000000 || rsp_id !== 2'd3) begin errors++; $display("FAIL sign_zero: got data=%h id=%0d required 00000000/3", rsp_data, rsp_id); end
    cycle();
    rsp_ready = 1'b0;
  endtask

  task automatic test_wrap();
    set_op(0, 32'h12345678, 32'h9ABCDEF0);
    grant_log.delete();
    req_valid = 4'b1001; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_first: got %b required 0001", req_ready); end
    cycle();
    req_valid = 4'b1000;
    cycle();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_second: got %b required 1000", req_ready); end
    cycle();
    req_valid = '0;
    repeat (2) cycle();
    checks++; if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
      errors++; $display("FAIL wrap_order: got %p required 0,3", grant_log); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_op(1, 32'h3F800000, 32'h41200000);
    req_valid = 4'b0010; rsp_ready = 1'b0;
    cycle();
    checks++; if (mul_in1 !== 32'h3F800000 || busy !== 1'b1) begin errors++; $display("FAIL rm_calc: got mul_in1=%h busy=%b required 3f800000/1", mul_in1, busy); end
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async: got v=%b busy=%b required 0/0", rsp_valid, busy); end
    checks++; if (mul_in1 !== 32'h0 || mul_in2 !== 32'h0) begin errors++; $display("FAIL rm_mul_in: got %h/%h required 0/0", mul_in1, mul_in2); end
    sb.delete();
    #1;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_regrant: got %b required 0001", req_ready); end
    cycle();
    req_valid = '0; rsp_ready = 1'b1;
    repeat (3) cycle();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sign_zero();
    test_wrap();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
